axi_lite_master: RTL
====================

// Module: axi_lite_master
// PURPOSE
//  AXI-Lite initiator for the 4-bit-address / 8-bit-data AXI-Lite slave bus.
//  - Accepts single read/write commands on a simple valid/ready user port.
//  - Runs the AR/R or AW/W/B handshakes against the slave.
//  - Returns read data and completion as a one-cycle response pulse.
//  - One transaction outstanding at a time.
// PARAMETERS
//  ADDR_W          4   address width (read_address/write_address/cmd_addr)
//  DATA_W          8   data width (data_read/write_data/cmd_wdata/rsp_rdata)
//  TIMEOUT_CYCLES  64  wait-state cycle limit; used only with AXI_MASTER_TIMEOUT_EN
// PORTS
//  s_clk          in   1       clock, all logic on posedge
//  rst            in   1       synchronous, active-high reset
//  cmd_valid      in   1       user command present
//  cmd_ready      out  1       master idle, command accepted when cmd_valid&&cmd_ready
//  cmd_write      in   1       1=write, 0=read
//  cmd_addr       in   ADDR_W  target address
//  cmd_wdata      in   DATA_W  write data (ignored for reads)
//  rsp_valid      out  1       one-cycle completion pulse
//  rsp_write      out  1       completed op was a write
//  rsp_rdata      out  DATA_W  read data captured from R channel (0 for writes)
//  rsp_err        out  1       transaction aborted by timeout
//  read_address   out  ADDR_W  AR address
//  AR_VALID       out  1       AR valid
//  AR_READY       in   1       AR ready
//  data_read      in   DATA_W  R data
//  R_VALID        in   1       R valid
//  R_READY        out  1       R ready
//  write_address  out  ADDR_W  AW address
//  AW_VALID       out  1       AW valid
//  AW_READY       in   1       AW ready
//  write_data     out  DATA_W  W data
//  W_VALID        out  1       W valid
//  W_READY        in   1       W ready
//  B_VALID        in   1       write response valid
//  B_READY        out  1       write response ready
// BEHAVIOUR
//  Reset and registers
//  - rst sampled on s_clk only; takes priority over everything.
//  - On rst: state=IDLE; every output 0, except cmd_ready=1.
//  - Reset mid-transaction abandons the transfer: no rsp_valid; all VALID/READY low next cycle.
//  - All outputs registered; cmd_ready = (state==IDLE).
//  States: IDLE, AR, R, AW, W, B.
//  - IDLE: on cmd accept, latch addr/wdata and drive the address/data buses.
//    - read:  AR_VALID=1, go to AR.
//    - write: AW_VALID=1, write_data=cmd_wdata, go to AW.
//    - First VALID is high the cycle after the accept edge.
//  - AR: hold AR_VALID and read_address stable until AR_VALID&&AR_READY sampled high.
//    - Then AR_VALID=0, R_READY=1, go to R.
//  - R: on R_VALID&&R_READY:
//    - capture data_read into rsp_rdata; R_READY=0;
//    - pulse rsp_valid (rsp_write=0); go to IDLE.
//  - AW: hold until AW_VALID&&AW_READY.
//    - Then AW_VALID=0, W_VALID=1, go to W. AW and W are strictly sequential.
//  - W: hold W_VALID and write_data until W_VALID&&W_READY.
//    - Then W_VALID=0, B_READY=1, go to B.
//  - B: on B_VALID&&B_READY:
//    - B_READY=0; pulse rsp_valid (rsp_write=1, rsp_rdata=0); go to IDLE.
//  Handshake and timing rules
//  - A VALID never drops before its handshake; address/data never change while VALID is high.
//  - READY already high when VALID arrives completes in that same cycle.
//  - Minimum latency, read: accept -> AR_VALID +1 -> handshake -> R_READY +1 -> R beat -> rsp_valid +1.
//  - rsp_valid is high the same cycle cmd_ready returns to 1; a new command may be accepted that cycle.
//  - rsp_rdata/rsp_write/rsp_err hold their values until the next response.
//  - Inputs that are high outside their wait state are ignored (stray R_VALID/B_VALID in IDLE).
// CONFIGURATION
//  AXI_MASTER_TIMEOUT_EN defined:
//  - Counter clears on entering each wait state (AR,R,AW,W,B) and increments per cycle in it.
//  - At count==TIMEOUT_CYCLES-1 without handshake: drop all VALID/READY, go to IDLE,
//    pulse rsp_valid with rsp_err=1, rsp_rdata=0.
//  - A handshake in that same cycle wins over the timeout.
//  not defined:
//  - No counter; wait states hold indefinitely; rsp_err tied 0.
// TESTING
//  - Reset: rst=1 for 2 cycles -> cmd_ready=1, all VALID/READY=0, rsp_valid=0.
//  - Read: cmd read addr=4'h5, slave memory[5]=8'h55 -> AR with read_address=5, R_READY handshake,
//    rsp_valid pulse, rsp_rdata=8'h55, rsp_write=0.
//  - Write then read-back: write addr=4'hA data=8'h3C -> AW,W,B sequence, rsp_write=1;
//    then read addr=4'hA -> rsp_rdata=8'h3C.
//  - Backpressure: AR_READY held 0 for 5 cycles -> AR_VALID and read_address stable throughout;
//    completes correctly after AR_READY.
//  - Reset mid-write: assert rst while in W -> next cycle W_VALID=0, cmd_ready=1, no rsp_valid.
//  - Timeout (macro on, TIMEOUT_CYCLES=8): B_VALID never asserted -> rsp_valid with rsp_err=1
//    after 8 cycles in B, B_READY=0.
//    Macro off: B_READY stays high indefinitely, rsp_err always 0.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: single commands from a valid/ready user port run over AR/R or AW/W/B.
// Define AXI_MASTER_TIMEOUT_EN to abort a wait state after TIMEOUT_CYCLES cycles without a handshake.
module axi_lite_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              s_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] read_address,
  output logic              AR_VALID,
  input  logic              AR_READY,
  input  logic [DATA_W-1:0] data_read,
  input  logic              R_VALID,
  output logic              R_READY,
  output logic [ADDR_W-1:0] write_address,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [DATA_W-1:0] write_data,
  output logic              W_VALID,
  input  logic              W_READY,
  input  logic              B_VALID,
  output logic              B_READY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0] state;
  logic       hs_ar, hs_r, hs_aw, hs_w, hs_b, hs_any;
  logic       to_hit;

  // Handshakes only count in their own wait state, so stray inputs elsewhere are ignored.
  assign hs_ar  = (state == S_AR) && AR_VALID && AR_READY;
  assign hs_r   = (state == S_R)  && R_VALID  && R_READY;
  assign hs_aw  = (state == S_AW) && AW_VALID && AW_READY;
  assign hs_w   = (state == S_W)  && W_VALID  && W_READY;
  assign hs_b   = (state == S_B)  && B_VALID  && B_READY;
  assign hs_any = hs_ar || hs_r || hs_aw || hs_w || hs_b;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Any state change clears the count, so each wait state starts from zero.
  always_ff @(posedge s_clk) begin
    if (rst || (state == S_IDLE) || hs_any) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign to_hit = (state != S_IDLE) && (wait_cnt == CNT_LAST);
`else
  // No timeout in this build: comparison is constant false.
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge s_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      read_address  <= '0;
      AR_VALID      <= 1'b0;
      R_READY       <= 1'b0;
      write_address <= '0;
      AW_VALID      <= 1'b0;
      write_data    <= '0;
      W_VALID       <= 1'b0;
      B_READY       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (to_hit && !hs_any) begin
        AR_VALID  <= 1'b0;
        R_READY   <= 1'b0;
        AW_VALID  <= 1'b0;
        W_VALID   <= 1'b0;
        B_READY   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
        rsp_write <= (state == S_AW) || (state == S_W) || (state == S_B);
        cmd_ready <= 1'b1;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              if (cmd_write) begin
                write_address <= cmd_addr;
                write_data    <= cmd_wdata;
                AW_VALID      <= 1'b1;
                state         <= S_AW;
              end else begin
                read_address <= cmd_addr;
                AR_VALID     <= 1'b1;
                state        <= S_AR;
              end
            end
          end
          S_AR: begin
            if (hs_ar) begin
              AR_VALID <= 1'b0;
              R_READY  <= 1'b1;
              state    <= S_R;
            end
          end
          S_R: begin
            if (hs_r) begin
              R_READY   <= 1'b0;
              rsp_rdata <= data_read;
              rsp_write <= 1'b0;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_AW: begin
            if (hs_aw) begin
              AW_VALID <= 1'b0;
              W_VALID  <= 1'b1;
              state    <= S_W;
            end
          end
          S_W: begin
            if (hs_w) begin
              W_VALID <= 1'b0;
              B_READY <= 1'b1;
              state   <= S_B;
            end
          end
          S_B: begin
            if (hs_b) begin
              B_READY   <= 1'b0;
              rsp_rdata <= '0;
              rsp_write <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
          default: begin
            AR_VALID  <= 1'b0;
            R_READY   <= 1'b0;
            AW_VALID  <= 1'b0;
            W_VALID   <= 1'b0;
            B_READY   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
